// File: rtl/fnd_scan_decoder_pkg.sv
// fnd_pkg: shared constants and types for the FND scan decoder.
//   SEG_0..SEG_9, SEG_BLANK : active-low segment codes {dp,g,f,e,d,c,b,a}
//   DIGIT_SEL0..3           : active-low digit select codes (d0 = ones)
//   fsm_state_t             : frame FSM state encoding
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] DIGIT_SEL0 = 4'b1110;
  localparam logic [3:0] DIGIT_SEL1 = 4'b1101;
  localparam logic [3:0] DIGIT_SEL2 = 4'b1011;
  localparam logic [3:0] DIGIT_SEL3 = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fnd_scan_decoder_seg7_to_bcd.sv
// seg7_to_bcd: combinational active-low 7-segment pattern to BCD decoder.
//   seg      in  8  active-low segments {dp,g,f,e,d,c,b,a}
//   bcd      out 4  decoded digit 0..9 (0 when code_err)
//   code_err out 1  pattern is not one of the ten digit codes
module seg7_to_bcd
  import fnd_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] bcd,
  output logic       code_err
);

  always_comb begin
    bcd      = '0;
    code_err = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: code_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: receive side of a 4-digit multiplexed FND interface.
// Synchronizes the scanned select/segment lines, captures each settled digit,
// assembles a d0..d3 frame and converts it to binary.
//   clk         in  1   system clock
//   reset       in  1   asynchronous active-high reset
//   fnd_digit   in  4   active-low digit select
//   fnd_data    in  8   active-low segments {dp,g,f,e,d,c,b,a}
//   value       out 14  binary value of last good frame
//   digits_bcd  out 16  {d3,d2,d1,d0} BCD of last good frame
//   value_valid out 1   one-cycle pulse when value/digits_bcd update
//   frame_err   out 1   one-cycle pulse when a frame is aborted
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fnd_digit,
  input  logic [7:0]  fnd_data,
  output logic [13:0] value,
  output logic [15:0] digits_bcd,
  output logic        value_valid,
  output logic        frame_err
);

  localparam logic [15:0] CAPTURE_AT = 16'(SETTLE_CYCLES - 1);

  // input synchronizers
  logic [3:0]  digit_meta, digit_sync;
  logic [7:0]  data_meta, data_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_meta <= '1;
      digit_sync <= '1;
      data_meta  <= '1;
      data_sync  <= '1;
    end else begin
      digit_meta <= fnd_digit;
      digit_sync <= digit_meta;
      data_meta  <= fnd_data;
      data_sync  <= data_meta;
    end
  end

  // settle detection
  logic [11:0] prev_sample;
  logic [15:0] settle_cnt;
  logic        captured;
  logic        changed;
  logic        sel_legal;
  logic [1:0]  sel_idx;
  logic        capture;

  always_comb begin
    sel_legal = 1'b1;
    sel_idx   = 2'd0;
    case (digit_sync)
      DIGIT_SEL0: sel_idx = 2'd0;
      DIGIT_SEL1: sel_idx = 2'd1;
      DIGIT_SEL2: sel_idx = 2'd2;
      DIGIT_SEL3: sel_idx = 2'd3;
      default:    sel_legal = 1'b0;
    endcase
  end

  assign changed = ({digit_sync, data_sync} != prev_sample);
  // captured keeps a dwell longer than SETTLE_CYCLES from firing twice
  assign capture = !changed && !captured && sel_legal && (settle_cnt == CAPTURE_AT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sample <= {4'b1111, 8'hFF};
      settle_cnt  <= '0;
      captured    <= 1'b0;
    end else begin
      prev_sample <= {digit_sync, data_sync};
      if (changed) begin
        settle_cnt <= '0;
        captured   <= 1'b0;
      end else begin
        if (settle_cnt != '1)
          settle_cnt <= settle_cnt + 16'd1;
        if (capture)
          captured <= 1'b1;
      end
    end
  end

  // segment decode
  logic [3:0] seg_bcd;
  logic       code_err;

  seg7_to_bcd u_seg7_to_bcd (
    .seg      (data_sync),
    .bcd      (seg_bcd),
    .code_err (code_err)
  );

  // frame FSM
  fsm_state_t  state, state_next;
  logic [3:0]  digit_reg [4];
  logic        bad, bad_next;
  logic [1:0]  exp_idx, exp_next;
  logic [1:0]  conv_k;
  logic [13:0] acc;
  logic        store_en;
  logic        acc_clear;
  logic        acc_step;
  logic        valid_next;
  logic        err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    store_en   = 1'b0;
    bad_next   = bad;
    exp_next   = exp_idx;
    acc_clear  = 1'b0;
    acc_step   = 1'b0;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture && sel_idx == 2'd0) begin
          store_en   = 1'b1;
          bad_next   = code_err;
          exp_next   = 2'd1;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (capture) begin
          if (sel_idx == exp_idx) begin
            store_en = 1'b1;
            bad_next = bad | code_err;
            if (sel_idx == 2'd3) begin
              if (bad | code_err) begin
                err_next   = 1'b1;
                state_next = ST_IDLE;
              end else begin
                acc_clear  = 1'b1;
                state_next = ST_CONVERT;
              end
            end else begin
              exp_next = exp_idx + 2'd1;
            end
          end else begin
            // ordering error takes precedence over any code error
            err_next = 1'b1;
            if (sel_idx == 2'd0) begin
              store_en = 1'b1;
              bad_next = code_err;
              exp_next = 2'd1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_CONVERT: begin
        acc_step = 1'b1;
        if (conv_k == 2'd0)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        valid_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++)
        digit_reg[i] <= '0;
      bad         <= 1'b0;
      exp_idx     <= '0;
      conv_k      <= '0;
      acc         <= '0;
      value       <= '0;
      digits_bcd  <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      value_valid <= valid_next;
      frame_err   <= err_next;
      bad         <= bad_next;
      exp_idx     <= exp_next;
      if (store_en)
        digit_reg[sel_idx] <= seg_bcd;
      if (acc_clear) begin
        acc    <= '0;
        conv_k <= 2'd3;
      end else if (acc_step) begin
        // acc*10 as shift-add, most significant digit first
        acc    <= (acc << 3) + (acc << 1) + {10'd0, digit_reg[conv_k]};
        conv_k <= conv_k - 2'd1;
      end
      if (valid_next) begin
        value      <= acc;
        digits_bcd <= {digit_reg[3], digit_reg[2], digit_reg[1], digit_reg[0]};
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb_fnd_scan_decoder: directed self-checking bench for fnd_scan_decoder.
module tb_fnd_scan_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;
  logic [13:0] value;
  logic [15:0] digits_bcd;
  logic        value_valid;
  logic        frame_err;

  fnd_scan_decoder #(.SETTLE_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fnd_digit   (fnd_digit),
    .fnd_data    (fnd_data),
    .value       (value),
    .digits_bcd  (digits_bcd),
    .value_valid (value_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int valid_cyc = 0;
  int d3_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (value_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (value_valid && frame_err) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // called at a negedge; leaves the caller at a negedge
  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int dwell);
    fnd_digit = sel;
    fnd_data  = seg;
    if (sel == 4'b0111) d3_cyc = cyc;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] s3, input logic [7:0] s2,
                      input logic [7:0] s1, input logic [7:0] s0);
    drive(4'b1110, s0, 40);
    drive(4'b1101, s1, 40);
    drive(4'b1011, s2, 40);
    drive(4'b0111, s3, 40);
  endtask

  initial begin
    reset     = 1'b1;
    fnd_digit = 4'b1111;
    fnd_data  = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("rst_value", 32'(value), 0);
    check_eq("rst_bcd", 32'(digits_bcd), 0);
    check_eq("rst_valid", 32'(value_valid), 0);
    check_eq("rst_err", 32'(frame_err), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1234
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99);
    check_eq("t1_valid_cnt", 32'(valid_cnt), 1);
    check_eq("t1_err_cnt", 32'(err_cnt), 0);
    check_eq("t1_value", 32'(value), 1234);
    check_eq("t1_bcd", 32'(digits_bcd), 32'h1234);
    check_eq("t1_latency", 32'(valid_cyc - d3_cyc), 24);

    // 0000 then 9999 back to back
    scan(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check_eq("t2_value0", 32'(value), 0);
    check_eq("t2_bcd0", 32'(digits_bcd), 0);
    scan(8'h90, 8'h90, 8'h90, 8'h90);
    check_eq("t2_value9999", 32'(value), 9999);
    check_eq("t2_bcd9999", 32'(digits_bcd), 32'h9999);
    check_eq("t2_valid_cnt", 32'(valid_cnt), 3);
    check_eq("t2_err_cnt", 32'(err_cnt), 0);

    // d0,d1,d3 ordering error, then 0042
    drive(4'b1110, 8'hF9, 40);
    drive(4'b1101, 8'hA4, 40);
    drive(4'b0111, 8'hB0, 40);
    check_eq("t3_err_cnt", 32'(err_cnt), 1);
    check_eq("t3_valid_cnt", 32'(valid_cnt), 3);
    scan(8'hC0, 8'hC0, 8'h99, 8'hA4);
    check_eq("t3_value", 32'(value), 42);
    check_eq("t3_valid_cnt2", 32'(valid_cnt), 4);

    // blank d2 -> code error frame, value holds
    scan(8'h80, 8'hFF, 8'h82, 8'h92);
    check_eq("t4_err_cnt", 32'(err_cnt), 2);
    check_eq("t4_valid_cnt", 32'(valid_cnt), 4);
    check_eq("t4_value_hold", 32'(value), 42);
    // d0 too short to settle: rest of frame ignored
    drive(4'b1110, 8'hC0, 3);
    drive(4'b1101, 8'hC0, 40);
    drive(4'b1011, 8'hC0, 40);
    drive(4'b0111, 8'hF9, 40);
    check_eq("t4_short_valid", 32'(valid_cnt), 4);
    check_eq("t4_short_err", 32'(err_cnt), 2);

    // illegal select glitch, then 0507
    drive(4'b1100, 8'h99, 100);
    check_eq("t5_glitch_valid", 32'(valid_cnt), 4);
    check_eq("t5_glitch_err", 32'(err_cnt), 2);
    scan(8'hC0, 8'h92, 8'hC0, 8'hF8);
    check_eq("t5_value", 32'(value), 507);
    check_eq("t5_bcd", 32'(digits_bcd), 32'h0507);

    // reset during conversion
    drive(4'b1110, 8'h99, 40);
    drive(4'b1101, 8'hB0, 40);
    drive(4'b1011, 8'hA4, 40);
    drive(4'b0111, 8'hF9, 21);
    reset = 1'b1;
    #1;
    check_eq("t6_value_rst", 32'(value), 0);
    check_eq("t6_bcd_rst", 32'(digits_bcd), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_valid_cnt", 32'(valid_cnt), 5);
    check_eq("t6_value_after", 32'(value), 0);
    scan(8'hA4, 8'h99, 8'h82, 8'h80);
    check_eq("t6_value", 32'(value), 2468);
    check_eq("t6_bcd", 32'(digits_bcd), 32'h2468);
    check_eq("t6_valid_cnt2", 32'(valid_cnt), 6);
    check_eq("final_err_cnt", 32'(err_cnt), 2);
    check_eq("never_both", 32'(both_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
